rtc_bus_sequencer: RTL

Drives the multiplexed 8-bit address/data bus of the external real-time clock chip with one complete bus transaction per request. Requests come from the micro port-decode side: one-cycle write or read request, plus register address and write data. It sits directly downstream of the micro I/O interface and upstream of the chip pins CS, AD, RD, WR and the shared data bus. It returns read data and a completion pulse to the micro-facing logic.

---
 rtl/rtc_bus_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// Bus sequencer for the multiplexed-address/data RTC chip: one full CS/AD/RD/WR transaction per request.
// Optional RTC_IRQ_SYNC_EN: synchronise the active-low irq pin and emit a one-cycle pulse on its falling edge.
module rtc_bus_sequencer #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    input  logic       irq,
    output logic       irq_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_SET,
        S_A_PUL,
        S_A_HLD,
        S_D_SET,
        S_D_PUL,
        S_D_HLD,
        S_GAP
    } state_t;

    localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_is_wr;
    logic       w_is_wr_nxt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] w_addr_nxt;
    logic [7:0] w_wdata_nxt;
    logic       w_accept;

    logic       w_addr_ph;
    logic       w_data_ph;
    logic       w_cs;
    logic       w_ad;
    logic       w_rd;
    logic       w_wr;
    logic       w_oe;
    logic [7:0] w_bus;
    logic       w_done;
    logic       w_capture;

    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;
    logic [7:0] r_bus_out;
    logic       r_bus_oe;
    logic       r_cs;
    logic       r_ad;
    logic       r_rd;
    logic       r_wr;
    logic       r_irq_pulse;

    function automatic logic [7:0] load_for(input state_t s);
        case (s)
            S_A_SET, S_D_SET: return LD_SETUP;
            S_A_PUL, S_D_PUL: return LD_PULSE;
            S_A_HLD, S_D_HLD: return LD_HOLD;
            S_GAP:            return LD_GAP;
            default:          return '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_is_wr <= w_is_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (r_state == S_IDLE) begin
            if (req_wr || req_rd) begin
                w_accept    = 1'b1;
                w_state_nxt = S_A_SET;
            end
        end else if (r_cnt == '0) begin
            case (r_state)
                S_A_SET: w_state_nxt = S_A_PUL;
                S_A_PUL: w_state_nxt = S_A_HLD;
                S_A_HLD: w_state_nxt = S_D_SET;
                S_D_SET: w_state_nxt = S_D_PUL;
                S_D_PUL: w_state_nxt = S_D_HLD;
                S_D_HLD: w_state_nxt = S_GAP;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_cnt_nxt = r_cnt - 8'd1;
        end
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = load_for(w_state_nxt);
        end
    end

    // Pin levels are decoded from the next state so the registered outputs line up with r_state.
    always_comb begin
        w_is_wr_nxt = w_accept ? req_wr : r_is_wr;
        w_addr_nxt  = w_accept ? addr   : r_addr;
        w_wdata_nxt = w_accept ? wdata  : r_wdata;
        w_addr_ph   = (w_state_nxt == S_A_SET) || (w_state_nxt == S_A_PUL) ||
                      (w_state_nxt == S_A_HLD);
        w_data_ph   = (w_state_nxt == S_D_SET) || (w_state_nxt == S_D_PUL) ||
                      (w_state_nxt == S_D_HLD);
        w_cs        = !(w_addr_ph || w_data_ph);
        w_ad        = !w_addr_ph;
        w_wr        = !((w_state_nxt == S_A_PUL) || ((w_state_nxt == S_D_PUL) && w_is_wr_nxt));
        w_rd        = !((w_state_nxt == S_D_PUL) && !w_is_wr_nxt);
        w_oe        = w_addr_ph || (w_data_ph && w_is_wr_nxt);
        w_bus       = '0;
        if (w_addr_ph) begin
            w_bus = w_addr_nxt;
        end else if (w_data_ph && w_is_wr_nxt) begin
            w_bus = w_wdata_nxt;
        end
        w_done      = (r_state == S_D_HLD) && (r_cnt == '0);
        w_capture   = (r_state == S_D_PUL) && (r_cnt == '0) && !r_is_wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
            r_cs      <= 1'b1;
            r_ad      <= 1'b1;
            r_rd      <= 1'b1;
            r_wr      <= 1'b1;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done;
            r_bus_out <= w_bus;
            r_bus_oe  <= w_oe;
            r_cs      <= w_cs;
            r_ad      <= w_ad;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            if (w_capture) begin
                r_rdata <= bus_in;
            end
        end
    end

`ifdef RTC_IRQ_SYNC_EN
    logic r_irq_s1;
    logic r_irq_s2;
    logic r_irq_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_s1    <= 1'b1;
            r_irq_s2    <= 1'b1;
            r_irq_s3    <= 1'b1;
            r_irq_pulse <= 1'b0;
        end else begin
            r_irq_s1    <= irq;
            r_irq_s2    <= r_irq_s1;
            r_irq_s3    <= r_irq_s2;
            r_irq_pulse <= r_irq_s3 && !r_irq_s2;
        end
    end
`else
    logic w_irq_unused;
    assign w_irq_unused = irq;
    assign r_irq_pulse  = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign bus_out   = r_bus_out;
    assign bus_oe    = r_bus_oe;
    assign CS        = r_cs;
    assign AD        = r_ad;
    assign RD        = r_rd;
    assign WR        = r_wr;
    assign irq_pulse = r_irq_pulse;

endmodule
